// File: rtl/xfer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// xfer_pkg
// Shared types and constants for the transfer sequencer slice.
//   state_t      : sequencer FSM states
//   NBYTES/NWORDS: frame geometry (NBYTES must equal 2*NWORDS)
//   BA_W/WA_W    : engine byte / word address widths
//   TIMEOUT_DEF  : default WAIT budget in cycles; TO_W_DEF its counter width
// -----------------------------------------------------------------------------
package xfer_pkg;

  localparam int NBYTES      = 32;
  localparam int NWORDS      = 16;
  localparam int BA_W        = 5;
  localparam int WA_W        = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int TO_W_DEF    = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    RADDR,
    RDATA
  } state_t;

endpackage

// File: rtl/xfer_sequencer_if.sv
// -----------------------------------------------------------------------------
// xfer_sequencer_if
// Generic valid/ready stream of W-bit beats with an end-of-frame marker.
//   valid/data/last : driven by the producer (master)
//   ready           : driven by the consumer (slave)
// -----------------------------------------------------------------------------
interface xfer_sequencer_if #(
  parameter int W = 8
);

  logic         valid;
  logic [W-1:0] data;
  logic         last;
  logic         ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/xfer_timeout.sv
// -----------------------------------------------------------------------------
// xfer_timeout
// Loadable down-counter used as the WAIT-state watchdog.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force the count to zero
//   load       : load load_val (takes priority over en)
//   en         : count down one per cycle while non-zero
//   load_val   : reload value (budget - 1)
//   expire     : high while enabled with the count at zero (budget used up)
// -----------------------------------------------------------------------------
module xfer_timeout #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  // NOTE: the reset is synchronous, so rst_n is tested inside the clocked
  // block and not listed in the sensitivity list; all state updates use
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/xfer_sequencer.sv
// -----------------------------------------------------------------------------
// xfer_sequencer
// Front-end controller for the byte-to-word transfer engine. One frame per
// start: load NBYTES bytes into the engine, kick it, wait for done (with a
// watchdog), then stream NWORDS packed words out.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : frame request, sampled only in IDLE
//   s_in (slave)    : input byte stream (valid/data/ready; last unused)
//   wr_en/wr_add/data_wr : engine byte-memory write port
//   op_mode         : one-cycle engine kick
//   done            : engine completion level; only its rising edge counts
//   rd_add/data_out : engine word read port, data one cycle after address
//   m_out (master)  : output word stream, last on word NWORDS-1
//   busy            : high outside IDLE
//   frame_done      : one-cycle pulse after the last word handshake
//   err             : sticky watchdog flag, cleared by reset or next start
// -----------------------------------------------------------------------------
module xfer_sequencer
  import xfer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  xfer_sequencer_if.slave  s_in,
  output logic            wr_en,
  output logic [BA_W-1:0] wr_add,
  output logic [7:0]      data_wr,
  output logic            op_mode,
  input  logic            done,
  output logic [WA_W-1:0] rd_add,
  input  logic [15:0]     data_out,
  xfer_sequencer_if.master m_out,
  output logic            busy,
  output logic            frame_done,
  output logic            err
);

  localparam logic [BA_W-1:0] LAST_BYTE = BA_W'(NBYTES - 1);
  localparam logic [WA_W-1:0] LAST_WORD = WA_W'(NWORDS - 1);
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [BA_W-1:0] bc;
  logic [WA_W-1:0] wc;
  logic            done_q;

  logic byte_hs, word_hs, done_rise, last_word, to_expire;

  assign byte_hs   = (state == LOAD) && s_in.valid;
  assign word_hs   = (state == RDATA) && m_out.ready;
  // A done level left over from an earlier frame must not end WAIT.
  assign done_rise = done && !done_q;
  assign last_word = (wc == LAST_WORD);

  // Loaded in KICK so the count reaches zero on the TIMEOUT-th WAIT cycle.
  xfer_timeout #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == IDLE),
    .load     (state == KICK),
    .en       (state == WAIT),
    .load_val (TO_LOAD),
    .expire   (to_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bc         <= '0;
      wc         <= '0;
      done_q     <= 1'b0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_q     <= done;
      frame_done <= word_hs && last_word;
      if (state == IDLE && start) begin
        bc  <= '0;
        err <= 1'b0;
      end
      if (byte_hs) bc <= bc + 1'b1;
      if (state == WAIT) begin
        if (done_rise)      wc  <= '0;
        else if (to_expire) err <= 1'b1;
      end
      if (word_hs && !last_word) wc <= wc + 1'b1;
    end
  end

  // NOTE: state_nxt gets its default before the case, so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (byte_hs && bc == LAST_BYTE) state_nxt = KICK;
      KICK:    state_nxt = WAIT;
      WAIT: begin
        if (done_rise)      state_nxt = RADDR;
        else if (to_expire) state_nxt = IDLE;
      end
      RADDR:   state_nxt = RDATA;
      RDATA:   if (word_hs) state_nxt = last_word ? IDLE : RADDR;
      default: state_nxt = IDLE;
    endcase
  end

  assign s_in.ready  = (state == LOAD);
  assign wr_en       = byte_hs;
  assign wr_add      = bc;
  assign data_wr     = s_in.data;
  assign op_mode     = (state == KICK);
  // wc is held through RDATA, so the address stays put under backpressure.
  assign rd_add      = (state == RADDR || state == RDATA) ? wc : '0;
  assign m_out.valid = (state == RDATA);
  assign m_out.data  = data_out;
  assign m_out.last  = (state == RDATA) && last_word;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_xfer_sequencer
// Self-checking bench for xfer_sequencer with a behavioural engine memory and
// an expected-word scoreboard filled from the byte stimulus.
// -----------------------------------------------------------------------------
module tb_xfer_sequencer;
  import xfer_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done = 1'b0;
  logic        wr_en, op_mode, busy, frame_done, err;
  logic [4:0]  wr_add;
  logic [7:0]  data_wr;
  logic [3:0]  rd_add;
  logic [15:0] data_out;

  xfer_sequencer_if #(.W(8))  s_if ();
  xfer_sequencer_if #(.W(16)) m_if ();

  xfer_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_in       (s_if),
    .wr_en      (wr_en),
    .wr_add     (wr_add),
    .data_wr    (data_wr),
    .op_mode    (op_mode),
    .done       (done),
    .rd_add     (rd_add),
    .data_out   (data_out),
    .m_out      (m_if),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Engine model: byte memory, registered word read (high byte = even addr).
  logic [7:0] mem [NBYTES];
  always @(posedge clk) begin
    if (wr_en) mem[wr_add] <= data_wr;
    data_out <= {mem[{rd_add, 1'b0}], mem[{rd_add, 1'b1}]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int k);
    return 8'(2 * k + 1 + seed);
  endfunction

  // Scoreboard and per-frame observation counters.
  logic [15:0] sb [$];
  int cur_seed, wr_cnt, kicks, hs_cnt, word_idx, stall_seen, first_mv_cyc, rise_cyc;
  bit last_hs_q, fd_seen;

  always @(negedge clk) begin
    bit hs_last;
    hs_last = 1'b0;
    if (wr_en) begin
      check("wr_add", wr_add, wr_cnt);
      check("data_wr", data_wr, pat(cur_seed, wr_cnt));
      wr_cnt++;
    end
    if (op_mode) kicks++;
    if (m_if.valid) begin
      if (first_mv_cyc < 0) first_mv_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_word", m_if.valid, 1'b0);
      end else begin
        check("m_data", m_if.data, sb[0]);
        check("rd_add", rd_add, word_idx);
        check("m_last", m_if.last, word_idx == NWORDS - 1);
        if (m_if.ready) begin
          hs_last = (word_idx == NWORDS - 1);
          void'(sb.pop_front());
          word_idx++;
          hs_cnt++;
        end else begin
          stall_seen++;
        end
      end
    end
    check("frame_done", frame_done, last_hs_q);
    if (frame_done) fd_seen = 1'b1;
    last_hs_q = hs_last;
  end

  // mode: 0 normal done edge, 1 done never rises, 2 done stale-high then edge
  task automatic run_frame(input int seed, input bit gaps, input bit bp,
                           input int mode, input bit spam);
    int guard;
    int stall_drv;
    cur_seed = seed; wr_cnt = 0; kicks = 0; hs_cnt = 0; word_idx = 0;
    stall_seen = 0; first_mv_cyc = -1; rise_cyc = 0; fd_seen = 1'b0;
    sb.delete();
    if (mode != 1)
      for (int i = 0; i < NWORDS; i++) sb.push_back({pat(seed, 2 * i), pat(seed, 2 * i + 1)});
    if (mode != 2) done = 1'b0;
    m_if.ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    if (!spam) start = 1'b0;

    for (int k = 0; k < NBYTES; k++) begin
      s_if.valid = 1'b1;
      s_if.data  = pat(seed, k);
      guard = 0;
      @(negedge clk);
      if (k == 0) begin
        check("busy_after_start", busy, 1'b1);
        check("err_cleared", err, 1'b0);
      end
      while (!s_if.ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) check("s_ready_wait", s_if.ready, 1'b1);
      @(posedge clk); #1;
      if (gaps && k != NBYTES - 1) begin
        s_if.valid = 1'b0;
        s_if.data  = 8'hEE;
        @(posedge clk); #1;
      end
    end

    // Offer a 33rd byte during KICK; it must be refused.
    s_if.valid = 1'b1;
    s_if.data  = 8'hFF;
    start = 1'b0;
    @(negedge clk);
    check("op_mode_kick", op_mode, 1'b1);
    check("s_ready_kick", s_if.ready, 1'b0);
    check("wr_en_kick", wr_en, 1'b0);
    @(posedge clk); #1;
    s_if.valid = 1'b0;

    if (mode == 1) begin
      repeat (TIMEOUT - 1) @(posedge clk);
      @(negedge clk);
      check("err_before_to", err, 1'b0);
      check("busy_before_to", busy, 1'b1);
      @(negedge clk);
      check("err_at_to", err, 1'b1);
      check("busy_at_to", busy, 1'b0);
      check("to_no_words", hs_cnt, 0);
      check("to_no_valid", first_mv_cyc, -1);
    end else begin
      if (mode == 0) begin
        repeat (3) @(posedge clk); #1;
        done = 1'b1;
      end else begin
        repeat (2) @(posedge clk); #1;
        done = 1'b0;
        repeat (3) @(posedge clk); #1;
        done = 1'b1;
        rise_cyc = cyc;
      end
      stall_drv = 0;
      for (guard = 0; guard < 400 && !(hs_cnt == NWORDS && fd_seen); guard++) begin
        @(posedge clk); #1;
        if (bp && word_idx == 3 && stall_drv < 5 && m_if.valid) begin
          m_if.ready = 1'b0;
          stall_drv++;
        end else begin
          m_if.ready = 1'b1;
        end
      end
      check("word_handshakes", hs_cnt, NWORDS);
      check("frame_done_seen", fd_seen, 1'b1);
      check("sb_drained", sb.size(), 0);
      check("stall_cycles", stall_seen, bp ? 5 : 0);
      if (mode == 2) check("no_early_read", first_mv_cyc > rise_cyc, 1'b1);
      @(negedge clk);
      check("busy_end", busy, 1'b0);
    end
    check("write_count", wr_cnt, NBYTES);
    check("kick_count", kicks, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    cur_seed = 0; wr_cnt = 0; kicks = 0; hs_cnt = 0; word_idx = 0;
    stall_seen = 0; first_mv_cyc = -1; rise_cyc = 0;
    last_hs_q = 1'b0; fd_seen = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {s_if.ready, wr_en, wr_add, op_mode, rd_add, m_if.valid,
                         m_if.last, busy, frame_done, err}, 17'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 1'b0, 1'b0, 0, 1'b0);   // nominal: 0x0103 .. 0x3D3F
    run_frame(0, 1'b1, 1'b0, 0, 1'b0);   // s_valid gaps
    run_frame(0, 1'b0, 1'b1, 0, 1'b0);   // backpressure on word 3
    run_frame(2, 1'b0, 1'b0, 1, 1'b0);   // watchdog timeout
    run_frame(3, 1'b0, 1'b0, 0, 1'b0);   // start clears err, leaves done high
    run_frame(5, 1'b0, 1'b0, 2, 1'b0);   // stale done level

    // Reset in the middle of LOAD after 10 bytes.
    cur_seed = 9; wr_cnt = 0; sb.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_if.valid = 1'b1;
      s_if.data  = pat(9, k);
      @(posedge clk); #1;
    end
    s_if.valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    s_if.valid = 1'b1;
    s_if.data  = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    check("midload_reset_outs", {s_if.ready, wr_en, wr_add, op_mode, rd_add, m_if.valid,
                                 m_if.last, busy, frame_done, err}, 17'd0);
    check("midload_writes", wr_cnt, 10);
    s_if.valid = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(11, 1'b0, 1'b0, 0, 1'b1);  // restart at address 0, start held during LOAD

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/xfer_sequencer.md
Name: xfer_sequencer

Overview:
- Front-end controller for the byte-to-word transfer engine (`top_fsm`). Runs one frame per `start` pulse:
  - accepts a 32-byte valid/ready stream and writes it into the engine's byte memory;
  - pulses `op_mode`, then waits for `done` under a timeout;
  - streams the 16 packed 16-bit words out on a valid/ready master port.
- Replaces the bench-style manual write/kick/read sequencing with one hardware block.

Parameters:
- NBYTES, 32, bytes per frame; must be 2*NWORDS.
- NWORDS, 16, words per frame.
- TIMEOUT, 64, maximum cycles spent in WAIT before `err`.
- TO_W, 7, timeout counter width; TIMEOUT must be less than 2^TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  input byte accepted when high with s_valid.
- wr_en  out  1  engine memory write enable.
- wr_add  out  5  engine byte write address.
- data_wr  out  8  engine write data.
- op_mode  out  1  engine transfer kick; one-cycle pulse.
- done  in  1  engine transfer complete (level).
- rd_add  out  4  engine word read address.
- data_out  in  16  engine word read data, valid 1 cycle after rd_add.
- m_valid  out  1  output word valid.
- m_data  out  16  output word.
- m_last  out  1  high with m_valid on word NWORDS-1.
- m_ready  in  1  downstream accepts the word.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last word handshake.
- err  out  1  sticky timeout flag; cleared by reset or the next accepted start.

Behaviour:
- Reset (rst_n low at a clk edge, any state):
  - state goes to IDLE; all counters clear.
  - All outputs are 0: s_ready, wr_en, wr_add, op_mode, rd_add, m_valid, m_last, busy, frame_done, err.
  - Reset mid-frame abandons the frame. The engine memory contents are don't-care.
- IDLE: start=1 clears err and moves to LOAD; the byte counter bc is set to 0.
- LOAD:
  - s_ready=1. wr_en = s_valid and is combinational; wr_add = bc; data_wr = s_data.
  - On each handshake bc increments. Gaps in s_valid stall with no write.
  - The handshake at bc=NBYTES-1 moves to KICK. No 33rd byte is ever accepted.
- KICK: op_mode=1 for exactly this one cycle, s_ready=0. Next state is WAIT; the timeout counter tc is cleared.
- WAIT:
  - done is registered as done_q. The exit condition is a rising edge (done & ~done_q), so a level left high from a prior frame is ignored.
  - On the edge: go to RADDR with word counter wc=0.
  - tc increments every cycle. When tc reaches TIMEOUT-1 with no edge: set err=1 and go to IDLE; no words are output.
- RADDR: rd_add = wc. Next state is RDATA.
- RDATA:
  - m_valid=1, m_data=data_out, m_last=(wc==NWORDS-1).
  - rd_add is held and m_data is stable while m_ready=0.
  - On handshake with wc<NWORDS-1: wc increments and the state returns to RADDR (m_valid low for 1 cycle).
  - On the last handshake: frame_done=1 the following cycle, back to IDLE.
- Throughput: 1 word per 2 cycles with no backpressure.
- start outside IDLE is ignored; no queueing.
- Width rules:
  - bc is 5 bits and wc is 4 bits; both wrap naturally but never exceed terminal counts.
  - m_data passes data_out through unchanged; no byte reordering in this block.

Decomposition:
- Shared package `xfer_pkg`:
  - state enum (IDLE, LOAD, KICK, WAIT, RADDR, RDATA);
  - NBYTES/NWORDS constants;
  - address width constants (5, 4).
- Sub-module `xfer_timeout`: a loadable down-counter with clear, enable and expire outputs, reused for the WAIT timeout.
- Everything else stays in one FSM module.

Test Plan:
- Nominal frame: start, bytes 2*i+1 for i=0..31 back-to-back, m_ready=1.
  - Expect writes to addresses 0..31 and exactly one op_mode pulse.
  - Words come out in order {4i+1, 4i+3}: word0=0x0103, word1=0x0507, word15=0x3D3F with m_last.
  - Expect frame_done one cycle after the final handshake.
- Input gaps: s_valid toggled every other cycle.
  - Expect wr_en only on valid cycles, 32 writes total, with the same output words as the nominal frame.
  - s_ready drops in KICK; a 33rd byte is never written.
- Backpressure: m_ready low for 5 cycles on word 3.
  - m_valid stays high and m_data holds 0x0D0F with rd_add=3 steady.
  - No word is lost or duplicated; 16 handshakes total.
- Timeout: done tied low after the kick.
  - err=1 and busy=0 exactly TIMEOUT cycles after entering WAIT, with no m_valid.
  - The next start clears err.
- Stale done: done held high from the previous frame into a new frame.
  - The sequencer waits for the done low→high edge and does not read early.
- Reset mid-LOAD after 10 bytes: all outputs 0 the next cycle.
  - A new start restarts at wr_add=0; start pulses during busy are ignored.
